sonar_sweep_uc: RTL and testbench
=================================

Name: sonar_sweep_uc

Overview:
Parametrised control unit for the sonar sweep system. It sequences measure → serial transmit of N_DIGITS characters → servo step → inter-position wait, and owns the digit, position, interval and timeout counters internally. Compared with the previous sonar UC, it adds:
- an operating-mode select (continuous bounce, single sweep, fixed position);
- a measurement timeout with bounded retry and an error flag;
- a ligar-drop shutdown path.

It sits between the top-level sonar datapath (ultrasonic interface, serial TX, servo PWM) and the board controls.

Parameters:
N_DIGITS, 7, characters transmitted per position (≥2)
N_POS, 8, servo positions in a sweep (≥2)
INTERVAL_CYCLES, 50000000, clock cycles spent in ESPERA_INTERVALO (≥2)
TIMEOUT_CYCLES, 2500000, max cycles waiting for fim_medida per attempt (≥2)
MAX_RETRY, 2, extra measurement attempts after a timeout (≥0)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
ligar  in  1  level; start/keep running
interromper  in  1  level; hold in PREPARACAO
modo  in  2  00 continuous bounce, 01 single sweep, 10 fixed position, 11 treated as 00
fim_medida  in  1  pulse from sensor interface: measurement done
fim_transmissao  in  1  pulse from serial TX: character sent
zera  out  1  clear datapath (INICIAL, PREPARACAO)
zera_pwm  out  1  clear servo PWM (INICIAL)
medir_distancia  out  1  start measurement (MEDIR)
transmitir  out  1  start one character (TRANSMISSAO)
digito_idx  out  clog2(N_DIGITS)  index of character being sent
posicao  out  clog2(N_POS)  current servo position
pulso_posicao  out  1  one-cycle pulse: posicao updated (ATUALIZA_POS)
erro_medida  out  1  last measurement failed after all retries
varredura_fim  out  1  one-cycle pulse: single sweep complete
ocupado  out  1  state ≠ INICIAL
db_estado  out  4  state code

Behaviour:
Outputs and state:
- Moore outputs are decoded from the state register. Counters and erro_medida are registered.
- Reset drives state INICIAL, digito_idx=0, posicao=0, direction=up, erro_medida=0, all counters=0.
- In INICIAL, zera=zera_pwm=1 and all other outputs are 0 (db_estado=0).

States (db_estado code) and transitions:
- INICIAL(0): ligar → PREPARACAO. posicao←0, dir←up.
- PREPARACAO(1): ligar=0 → INICIAL (priority over everything else); else interromper → stay; else → MEDIR. Clears digito_idx, retry count and erro_medida.
- MEDIR(2): → ESPERA_MEDIDA. Clears timeout counter.
- ESPERA_MEDIDA(3): fim_medida → TRANSMISSAO; else timeout counter == TIMEOUT_CYCLES-1 → FALHA_MEDIDA. If fim_medida arrives in the timeout cycle, fim_medida wins.
- FALHA_MEDIDA(10): retry < MAX_RETRY → retry++, go to MEDIR; else set erro_medida=1, go to TRANSMISSAO (the datapath sends its error code).
- TRANSMISSAO(4): → ESPERA_TRANSMISSAO.
- ESPERA_TRANSMISSAO(5): fim_transmissao with digito_idx==N_DIGITS-1 → PROXIMA_POSICAO; fim_transmissao otherwise → PROXIMO_DIGITO.
- PROXIMO_DIGITO(6): digito_idx++, go to TRANSMISSAO.
- PROXIMA_POSICAO(7):
  - modo=10: go to ESPERA_INTERVALO, posicao unchanged.
  - modo=01 and posicao==N_POS-1: go to FIM_VARREDURA.
  - Otherwise: go to ATUALIZA_POS. Step posicao in the current direction. modo=00 reverses direction at the ends (N_POS-1 → N_POS-2, 0 → 1); it never wraps.
- ATUALIZA_POS(8): pulso_posicao=1, go to ESPERA_INTERVALO.
- ESPERA_INTERVALO(9): interval counter runs 0..INTERVAL_CYCLES-1, so the state lasts exactly INTERVAL_CYCLES cycles, then goes to PREPARACAO. ligar=0 → INICIAL immediately.
- FIM_VARREDURA(11): varredura_fim=1, go to INICIAL. posicao is reset to 0 there.
- Unused codes: go to INICIAL; db_estado=15.

Boundary rules:
- A mode change takes effect at the next PROXIMA_POSICAO only.
- modo=01 started with posicao 0 visits every position once, then ends.
- ligar=0 outside PREPARACAO/ESPERA_INTERVALO is ignored until the current position's transmission completes.
- Async reset mid-transmission returns everything to reset values within the same cycle.
- fim_medida/fim_transmissao pulses in states not waiting for them are ignored.
- erro_medida stays set through transmission and the interval; it clears in PREPARACAO.

Test Plan:
Bench parameters: N_DIGITS=3, N_POS=3, INTERVAL_CYCLES=4, TIMEOUT_CYCLES=8, MAX_RETRY=1.
1. Reset, ligar=1, modo=00, fim_medida 3 cycles after medir_distancia, fim_transmissao 2 cycles after each transmitir → 3 transmitir pulses with digito_idx 0,1,2, pulso_posicao, posicao 0→1, ESPERA_INTERVALO exactly 4 cycles. Continuing, posicao goes 1→2→1→0→1 (bounce, no wrap).
2. modo=01 → posicao visits 0,1,2; after the position-2 transmission, varredura_fim pulses once, state returns to 0, posicao=0, ocupado=0.
3. Never assert fim_medida → medir_distancia pulses twice, each wait exactly 8 cycles, then erro_medida=1 and 3 characters are transmitted. erro_medida clears at the next PREPARACAO.
4. fim_medida in the same cycle the timeout count reaches 7 → goes to TRANSMISSAO, no retry, erro_medida=0.
5. modo=10 over 3 cycles of operation → posicao stays 0 and pulso_posicao is never asserted. interromper=1 holds the FSM in PREPARACAO (db_estado=1, zera=1) until released. ligar=0 during ESPERA_INTERVALO → INICIAL next cycle.
6. Async reset asserted during ESPERA_TRANSMISSAO with digito_idx=1 → same cycle: db_estado=0, digito_idx=0, posicao=0, transmitir=0.

Source files
------------

// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit: measure, transmit N_DIGITS characters, step the servo, wait.
// Adds operating modes, a measurement timeout with bounded retry, and shutdown when ligar drops.
module sonar_sweep_uc #(
  parameter int N_DIGITS        = 7,
  parameter int N_POS           = 8,
  parameter int INTERVAL_CYCLES = 50000000,
  parameter int TIMEOUT_CYCLES  = 2500000,
  parameter int MAX_RETRY       = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ligar,
  input  logic                        interromper,
  input  logic [1:0]                  modo,
  input  logic                        fim_medida,
  input  logic                        fim_transmissao,
  output logic                        zera,
  output logic                        zera_pwm,
  output logic                        medir_distancia,
  output logic                        transmitir,
  output logic [$clog2(N_DIGITS)-1:0] digito_idx,
  output logic [$clog2(N_POS)-1:0]    posicao,
  output logic                        pulso_posicao,
  output logic                        erro_medida,
  output logic                        varredura_fim,
  output logic                        ocupado,
  output logic [3:0]                  db_estado
);

  localparam int DW = $clog2(N_DIGITS);
  localparam int PW = $clog2(N_POS);
  localparam int IW = $clog2(INTERVAL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_POS - 1);
  localparam logic [IW-1:0] INT_LAST  = IW'(INTERVAL_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    INICIAL            = 4'd0,
    PREPARACAO         = 4'd1,
    MEDIR              = 4'd2,
    ESPERA_MEDIDA      = 4'd3,
    TRANSMISSAO        = 4'd4,
    ESPERA_TRANSMISSAO = 4'd5,
    PROXIMO_DIGITO     = 4'd6,
    PROXIMA_POSICAO    = 4'd7,
    ATUALIZA_POS       = 4'd8,
    ESPERA_INTERVALO   = 4'd9,
    FALHA_MEDIDA       = 4'd10,
    FIM_VARREDURA      = 4'd11
  } state_t;

  state_t        state, next_state;
  logic [IW-1:0] interval_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [RW-1:0] retry_cnt;
  logic          dir_up;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= next_state;
  end

  always_comb begin
    next_state      = state;
    zera            = 1'b0;
    zera_pwm        = 1'b0;
    medir_distancia = 1'b0;
    transmitir      = 1'b0;
    pulso_posicao   = 1'b0;
    varredura_fim   = 1'b0;
    ocupado         = (state != INICIAL);
    db_estado       = state;
    case (state)
      INICIAL: begin
        zera     = 1'b1;
        zera_pwm = 1'b1;
        if (ligar) next_state = PREPARACAO;
      end
      PREPARACAO: begin
        zera = 1'b1;
        if (!ligar)            next_state = INICIAL;
        else if (!interromper) next_state = MEDIR;
      end
      MEDIR: begin
        medir_distancia = 1'b1;
        next_state      = ESPERA_MEDIDA;
      end
      // A measurement landing in the timeout cycle still counts as success.
      ESPERA_MEDIDA: begin
        if (fim_medida)                    next_state = TRANSMISSAO;
        else if (timeout_cnt == TOUT_LAST) next_state = FALHA_MEDIDA;
      end
      FALHA_MEDIDA: begin
        if (retry_cnt < RETRY_MAX) next_state = MEDIR;
        else                       next_state = TRANSMISSAO;
      end
      TRANSMISSAO: begin
        transmitir = 1'b1;
        next_state = ESPERA_TRANSMISSAO;
      end
      ESPERA_TRANSMISSAO: begin
        if (fim_transmissao)
          next_state = (digito_idx == DIG_LAST) ? PROXIMA_POSICAO : PROXIMO_DIGITO;
      end
      PROXIMO_DIGITO: next_state = TRANSMISSAO;
      PROXIMA_POSICAO: begin
        if (modo == 2'b10)                              next_state = ESPERA_INTERVALO;
        else if (modo == 2'b01 && posicao == POS_LAST)  next_state = FIM_VARREDURA;
        else                                            next_state = ATUALIZA_POS;
      end
      ATUALIZA_POS: begin
        pulso_posicao = 1'b1;
        next_state    = ESPERA_INTERVALO;
      end
      ESPERA_INTERVALO: begin
        if (!ligar)                        next_state = INICIAL;
        else if (interval_cnt == INT_LAST) next_state = PREPARACAO;
      end
      FIM_VARREDURA: begin
        varredura_fim = 1'b1;
        next_state    = INICIAL;
      end
      default: begin
        next_state = INICIAL;
        db_estado  = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      interval_cnt <= '0;
      timeout_cnt  <= '0;
      retry_cnt    <= '0;
      digito_idx   <= '0;
      posicao      <= '0;
      dir_up       <= 1'b1;
      erro_medida  <= 1'b0;
    end else begin
      interval_cnt <= (state == ESPERA_INTERVALO) ? interval_cnt + 1'b1 : '0;
      if (state == MEDIR)              timeout_cnt <= '0;
      else if (state == ESPERA_MEDIDA) timeout_cnt <= timeout_cnt + 1'b1;

      case (state)
        INICIAL: begin
          posicao <= '0;
          dir_up  <= 1'b1;
        end
        PREPARACAO: begin
          digito_idx  <= '0;
          retry_cnt   <= '0;
          erro_medida <= 1'b0;
        end
        PROXIMO_DIGITO: digito_idx <= digito_idx + 1'b1;
        FALHA_MEDIDA: begin
          if (retry_cnt < RETRY_MAX) retry_cnt   <= retry_cnt + 1'b1;
          else                       erro_medida <= 1'b1;
        end
        // Bounce off either end instead of wrapping.
        PROXIMA_POSICAO: begin
          if (next_state == ATUALIZA_POS) begin
            if (dir_up) begin
              if (posicao == POS_LAST) begin
                posicao <= posicao - 1'b1;
                dir_up  <= 1'b0;
              end else begin
                posicao <= posicao + 1'b1;
              end
            end else begin
              if (posicao == '0) begin
                posicao <= posicao + 1'b1;
                dir_up  <= 1'b1;
              end else begin
                posicao <= posicao - 1'b1;
              end
            end
          end
        end
        default: ;
      endcase

      // Every path into INICIAL lands with idle register values.
      if (next_state == INICIAL) begin
        posicao     <= '0;
        dir_up      <= 1'b1;
        digito_idx  <= '0;
        retry_cnt   <= '0;
        erro_medida <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Directed bench for sonar_sweep_uc: auto-responding sensor/TX models and a
// scoreboard of expected (erro, posicao, digito) per transmitted character.
`timescale 1ns/1ps
module tb_sonar_sweep_uc;
  localparam int ND = 3, NP = 3, IC = 4, TC = 8, MR = 1;

  logic       clock, reset, ligar, interromper;
  logic [1:0] modo;
  logic       fim_medida, fim_transmissao;
  logic       zera, zera_pwm, medir_distancia, transmitir, pulso_posicao;
  logic       erro_medida, varredura_fim, ocupado;
  logic [1:0] digito_idx, posicao;
  logic [3:0] db_estado;

  int checks = 0, failures = 0;
  int med_dly, tx_dly;
  int med_cnt, pulse_cnt, sweep_cnt, med_wait_len;
  int base_med, base_pulse, base_sweep, n;
  int exp_tx[$];
  int exp_pos[$];

  sonar_sweep_uc #(.N_DIGITS(ND), .N_POS(NP), .INTERVAL_CYCLES(IC),
                   .TIMEOUT_CYCLES(TC), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .interromper(interromper),
    .modo(modo), .fim_medida(fim_medida), .fim_transmissao(fim_transmissao),
    .zera(zera), .zera_pwm(zera_pwm), .medir_distancia(medir_distancia),
    .transmitir(transmitir), .digito_idx(digito_idx), .posicao(posicao),
    .pulso_posicao(pulso_posicao), .erro_medida(erro_medida),
    .varredura_fim(varredura_fim), .ocupado(ocupado), .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int k = 0;
    while (db_estado !== code && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk(tag, {28'd0, db_estado}, {28'd0, code});
  endtask

  function automatic int mk(input int p, input int d, input int er);
    return er * 16 + p * 4 + d;
  endfunction

  task automatic push_pos(input int p, input int er);
    for (int d = 0; d < ND; d++) exp_tx.push_back(mk(p, d, er));
  endtask

  initial begin
    reset = 1'b1; ligar = 1'b0; interromper = 1'b0; modo = 2'b00;
    fim_medida = 1'b0; fim_transmissao = 1'b0;
    med_dly = 3; tx_dly = 2;
    med_cnt = 0; pulse_cnt = 0; sweep_cnt = 0; med_wait_len = 0;

    fork
      begin : sensor_model
        forever begin
          @(negedge clock);
          if (medir_distancia && med_dly > 0) begin
            repeat (med_dly) @(negedge clock);
            fim_medida = 1'b1;
            @(negedge clock);
            fim_medida = 1'b0;
          end
        end
      end
      begin : tx_model
        forever begin
          @(negedge clock);
          if (transmitir) begin
            repeat (tx_dly) @(negedge clock);
            fim_transmissao = 1'b1;
            @(negedge clock);
            fim_transmissao = 1'b0;
          end
        end
      end
      begin : monitor
        logic [3:0] prev;
        int run, e;
        prev = 4'd0;
        run  = 0;
        forever begin
          @(negedge clock);
          if (db_estado == prev) run++;
          else begin
            if (prev == 4'd3) begin
              med_wait_len = run;
              if (db_estado == 4'd10) chk("timeout_wait_len", run, TC);
            end
            if (prev == 4'd9 && db_estado == 4'd1) chk("interval_len", run, IC);
            prev = db_estado;
            run  = 1;
          end
          if (medir_distancia) med_cnt++;
          if (varredura_fim) sweep_cnt++;
          if (transmitir) begin
            e = (exp_tx.size() > 0) ? exp_tx.pop_front() : -1;
            chk("tx_char", {27'd0, erro_medida, posicao, digito_idx}, e);
          end
          if (pulso_posicao) begin
            pulse_cnt++;
            e = (exp_pos.size() > 0) ? exp_pos.pop_front() : -1;
            chk("pos_pulse", {30'd0, posicao}, e);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_flags", {zera, zera_pwm, medir_distancia, transmitir, pulso_posicao,
                      erro_medida, varredura_fim, ocupado}, 8'b1100_0000);
    chk("rst_estado", db_estado, 0);
    chk("rst_digito", digito_idx, 0);
    chk("rst_posicao", posicao, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: continuous bounce 0->1->2->1->0->1->2
    push_pos(0, 0); push_pos(1, 0); push_pos(2, 0);
    push_pos(1, 0); push_pos(0, 0); push_pos(1, 0);
    exp_pos = '{1, 2, 1, 0, 1, 2};
    base_pulse = pulse_cnt;
    modo = 2'b00; ligar = 1'b1;
    n = 0;
    while (pulse_cnt - base_pulse < 6 && n < 1000) begin @(negedge clock); n++; end
    chk("t1_pulse_count", pulse_cnt - base_pulse, 6);
    wait_state(4'd9, 20, "t1_reach_interval");
    ligar = 1'b0;
    @(negedge clock);
    chk("t1_ligar_drop", db_estado, 0);
    chk("t1_idle_posicao", posicao, 0);
    chk("t1_tx_drained", exp_tx.size(), 0);

    // 2: single sweep 0,1,2 then end
    push_pos(0, 0); push_pos(1, 0); push_pos(2, 0);
    exp_pos = '{1, 2};
    base_sweep = sweep_cnt;
    modo = 2'b01; ligar = 1'b1;
    wait_state(4'd11, 300, "t2_reach_fim");
    chk("t2_varredura_fim", varredura_fim, 1);
    ligar = 1'b0;
    @(negedge clock);
    chk("t2_estado", db_estado, 0);
    chk("t2_posicao", posicao, 0);
    chk("t2_ocupado", ocupado, 0);
    repeat (3) @(negedge clock);
    chk("t2_sweep_once", sweep_cnt - base_sweep, 1);
    chk("t2_tx_drained", exp_tx.size(), 0);

    // 3: sensor never answers -> two attempts, error code transmitted
    push_pos(0, 1); push_pos(1, 0);
    exp_pos = '{1, 2};
    base_med = med_cnt;
    modo = 2'b00; med_dly = 0; ligar = 1'b1;
    wait_state(4'd4, 100, "t3_reach_tx");
    chk("t3_medir_pulses", med_cnt - base_med, 2);
    chk("t3_erro_set", erro_medida, 1);
    med_dly = 3;
    wait_state(4'd9, 100, "t3_reach_interval");
    chk("t3_erro_held", erro_medida, 1);
    wait_state(4'd2, 20, "t3_reach_medir");
    chk("t3_erro_cleared", erro_medida, 0);
    wait_state(4'd9, 100, "t3_reach_interval2");
    ligar = 1'b0;
    @(negedge clock);
    chk("t3_stop", db_estado, 0);
    chk("t3_tx_drained", exp_tx.size(), 0);

    // 4: fim_medida on the last timeout cycle wins
    push_pos(0, 0);
    exp_pos = '{1};
    base_med = med_cnt;
    med_dly = 8; ligar = 1'b1;
    wait_state(4'd4, 100, "t4_reach_tx");
    @(negedge clock);
    chk("t4_no_retry", med_cnt - base_med, 1);
    chk("t4_wait_len", med_wait_len, TC);
    chk("t4_erro_clear", erro_medida, 0);
    wait_state(4'd9, 100, "t4_reach_interval");
    ligar = 1'b0;
    @(negedge clock);
    chk("t4_stop", db_estado, 0);
    chk("t4_tx_drained", exp_tx.size(), 0);

    // 5: fixed position, interromper hold
    for (int i = 0; i < 4; i++) push_pos(0, 0);
    base_pulse = pulse_cnt;
    modo = 2'b10; med_dly = 3; ligar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_state(4'd9, 100, "t5_interval");
      wait_state(4'd1, 20, "t5_prep");
    end
    wait_state(4'd9, 100, "t5_interval3");
    interromper = 1'b1;
    wait_state(4'd1, 20, "t5_prep_hold");
    repeat (5) @(negedge clock);
    chk("t5_hold_estado", db_estado, 1);
    chk("t5_hold_zera", zera, 1);
    interromper = 1'b0;
    @(negedge clock);
    chk("t5_release", db_estado, 2);
    wait_state(4'd9, 100, "t5_interval4");
    chk("t5_posicao_fixed", posicao, 0);
    ligar = 1'b0;
    @(negedge clock);
    chk("t5_stop", db_estado, 0);
    chk("t5_no_pulses", pulse_cnt - base_pulse, 0);
    chk("t5_tx_drained", exp_tx.size(), 0);

    // 6: async reset mid-transmission
    exp_tx.push_back(mk(0, 0, 0));
    exp_tx.push_back(mk(0, 1, 0));
    modo = 2'b00; ligar = 1'b1;
    n = 0;
    while (!(db_estado == 4'd5 && digito_idx == 2'd1) && n < 100) begin @(negedge clock); n++; end
    chk("t6_reach_digit1", {db_estado, digito_idx}, {4'd5, 2'd1});
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_estado", db_estado, 0);
    chk("t6_rst_digito", digito_idx, 0);
    chk("t6_rst_posicao", posicao, 0);
    chk("t6_rst_transmitir", transmitir, 0);
    @(negedge clock);
    ligar = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6_idle", db_estado, 0);
    chk("t6_tx_drained", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
